bcd_serial_adder: RTL and testbench

//  Multi-digit packed-BCD adder/subtractor, digit-serial: one BCD digit per clock, least significant digit first.

---
 rtl/bcd_serial_adder_pkg.sv | 26 ++
 rtl/bcd_serial_adder_if.sv | 27 ++
 rtl/bcd_serial_adder_digit.sv | 32 +++
 rtl/bcd_serial_adder.sv | 132 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   state_e      : controller states IDLE -> RUN -> DONE -> IDLE
//   BCD_MAX      : largest legal BCD digit value (9)
//   BCD_CORR     : decimal correction added when a digit sum exceeds 9
//   nines_comp   : 9's complement of one digit (wraps mod 16 for bad digits)
//   digit_invalid: flags a nibble that is not a legal BCD digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/response bundle of the BCD serial adder.
//   master : drives start, sub, cin, a, b; observes busy, done, sum, cout, err
//   slave  : the adder side of the same signals
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic                  sub;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder_digit.sv
// Combinational single-digit BCD adder.
//   a_d_i, b_d_i : digit operands (values >9 are still summed mod 16)
//   c_i          : decimal carry in
//   s_o          : BCD digit result
//   c_o          : decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d_i,
  input  logic [3:0] b_d_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] t;
  logic [4:0] t_corr;

  assign t      = {1'b0, a_d_i} + {1'b0, b_d_i} + {4'd0, c_i};
  assign t_corr = t + {1'b0, BCD_CORR};

  always_comb begin
    if (t > {1'b0, BCD_MAX}) begin
      s_o = t_corr[3:0];
      c_o = 1'b1;
    end else begin
      s_o = t[3:0];
      c_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : slave side of bcd_serial_adder_if
//           start/sub/cin/a/b captured in IDLE; busy high in RUN;
//           done pulses one cycle; sum/cout/err held until next completion
// Subtraction is A + (9's complement of B) + 1; cout=1 means no borrow.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e            state_q,   state_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [W-1:0]      a_sr_q,    a_sr_d;
  logic [W-1:0]      b_sr_q,    b_sr_d;
  logic              carry_q,   carry_d;
  logic [W-1:0]      res_q,     res_d;
  logic              err_cap_q, err_cap_d;
  logic [W-1:0]      sum_q,     sum_d;
  logic              cout_q,    cout_d;
  logic              err_q,     err_d;

  logic [W-1:0]      b_eff;
  logic [DIGITS-1:0] dig_bad;
  logic [3:0]        dig_s;
  logic              dig_c;
  logic [W-1:0]      res_shift;

  // B is complemented at capture so RUN only ever adds.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_capture
    assign b_eff[4*gi +: 4] = bus.sub ? nines_comp(bus.b[4*gi +: 4]) : bus.b[4*gi +: 4];
    assign dig_bad[gi]      = digit_invalid(bus.a[4*gi +: 4]) | digit_invalid(bus.b[4*gi +: 4]);
  end

  bcd_digit_add u_digit (
    .a_d_i (a_sr_q[3:0]),
    .b_d_i (b_sr_q[3:0]),
    .c_i   (carry_q),
    .s_o   (dig_s),
    .c_o   (dig_c)
  );

  // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0].
  if (DIGITS == 1) begin : g_res_one
    assign res_shift = dig_s;
  end else begin : g_res_multi
    assign res_shift = {dig_s, res_q[W-1:4]};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    carry_d   = carry_q;
    res_d     = res_q;
    err_cap_d = err_cap_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d    = bus.a;
          b_sr_d    = b_eff;
          carry_d   = bus.sub | bus.cin;
          err_cap_d = |dig_bad;
          idx_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 4;
        b_sr_d  = b_sr_q >> 4;
        carry_d = dig_c;
        res_d   = res_shift;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = res_shift;
          cout_d  = dig_c;
          err_d   = err_cap_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      carry_q   <= 1'b0;
      res_q     <= '0;
      err_cap_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      carry_q   <= carry_d;
      res_q     <= res_d;
      err_cap_q <= err_cap_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder (DIGITS=4): directed vectors, scoreboard
// queue filled by the driver and drained by a monitor on each done pulse.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_seen;
  int   ops_pushed;
  logic [15:0] last_sum;
  exp_t exp_q[$];

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got sum=%h with no operation outstanding", bus.sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum",  {16'd0, bus.sum},  {16'd0, e.sum});
        check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
        check("err",  {31'd0, bus.err},  {31'd0, e.err});
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic ee, input bit hold, input bit tog);
    int   cyc;
    int   bcnt;
    exp_t e;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
    e.sum = es; e.cout = ec; e.err = ee;
    exp_q.push_back(e);
    ops_pushed++;
    $display("op a=%h b=%h sub=%0d cin=%0d expect sum=%h cout=%0d err=%0d", a, b, s, c, es, ec, ee);
    @(posedge clk);
    cyc  = 0;
    bcnt = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.start = 1'b0;
      if (tog) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.sub = 1'($urandom); bus.cin = 1'($urandom);
      end
      if (bus.busy) begin
        bcnt++;
        check("sum_stable_in_run", {16'd0, bus.sum}, {16'd0, last_sum});
      end
      if (bus.done) break;
      if (cyc > 40) begin
        total++;
        bad++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected within %0d", cyc, DIGITS + 1);
        break;
      end
    end
    bus.start = 1'b0;
    check("done_latency", cyc, DIGITS + 1);
    check("busy_cycles", bcnt, DIGITS);
    last_sum = es;
    @(negedge clk);
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; done_seen = 0; ops_pushed = 0; last_sum = '0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sum",  {16'd0, bus.sum},  32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_err",  {31'd0, bus.err},  32'd0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
    run_op(16'h0000, 16'h0009, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 0, 0);
    run_op(16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 0, 0);
    run_op(16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0, 0, 0);
    run_op(16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0, 0);
    run_op(16'h0007, 16'h0008, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b0, 0, 0);
    // start held through RUN/DONE with inputs scrambled after capture
    run_op(16'h2468, 16'h1357, 1'b0, 1'b1, 16'h3826, 1'b0, 1'b0, 1, 1);
    repeat (3) @(negedge clk);
    check("no_requeue_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h5678; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_sum",  {16'd0, bus.sum},  32'd0);
    check("abort_cout", {31'd0, bus.cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_sum = '0;
    repeat (6) @(negedge clk);
    check("abort_no_done_count", done_seen, ops_pushed);

    run_op(16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_seen, ops_pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
